// File: rtl/latch373_ctl.sv
// latch373_ctl: sequences HOLD_N / OENB_N of a 74S373 latch bank used as a
// bus data holding register. A load opens the latch, waits for the data to
// settle, and acknowledges. A read enables the latch outputs for a fixed
// window and acknowledges in the final drive cycle.
//
// Optional feature macro: LATCH373_CTL_OVERWRITE_EN
//   defined     -> load_req while FULL overwrites the held data and sets the
//                  sticky overrun flag
//   not defined -> load_req while FULL stalls until the data is read, and
//                  overrun is tied low
module latch373_ctl #(
    parameter int unsigned OPEN_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned DRIVE_CYCLES  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load_req,
    output logic load_ack,
    input  logic rd_req,
    output logic rd_ack,
    output logic hold_n,
    output logic oenb_n,
    output logic full,
    output logic busy,
    output logic overrun
);

    // One shared down-counter, wide enough for the largest phase length.
    localparam int unsigned MAX_OS     = (OPEN_CYCLES > SETTLE_CYCLES) ? OPEN_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_OS > DRIVE_CYCLES) ? MAX_OS : DRIVE_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] OPEN_LD   = CNT_W'(OPEN_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] DRIVE_LD  = CNT_W'(DRIVE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPEN,
        ST_SETTLE,
        ST_FULL,
        ST_DRIVE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             hold_n_nxt;
    logic             oenb_n_nxt;
    logic             full_nxt;
    logic             load_ack_nxt;
    logic             rd_ack_nxt;
    logic             busy_nxt;
    logic             overrun_set;

    // Next-state, counter and next-output decode; every output is registered
    // below so nothing combinational reaches the pins.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        hold_n_nxt   = hold_n;
        oenb_n_nxt   = oenb_n;
        full_nxt     = full;
        load_ack_nxt = 1'b0;
        rd_ack_nxt   = 1'b0;
        overrun_set  = 1'b0;

        case (state)
            ST_IDLE: begin
                // Load wins when both requests are present; a lone read
                // stalls here because there is nothing to drive yet.
                if (load_req) begin
                    state_nxt  = ST_OPEN;
                    cnt_nxt    = OPEN_LD;
                    hold_n_nxt = 1'b1;
                end
            end

            ST_OPEN: begin
                if (cnt == CNT_ONE) begin
                    state_nxt  = ST_SETTLE;
                    cnt_nxt    = SETTLE_LD;
                    hold_n_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            ST_SETTLE: begin
                if (cnt == CNT_ONE) begin
                    state_nxt    = ST_FULL;
                    full_nxt     = 1'b1;
                    load_ack_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            ST_FULL: begin
                if (rd_req) begin
                    state_nxt  = ST_DRIVE;
                    cnt_nxt    = DRIVE_LD;
                    oenb_n_nxt = 1'b0;
                    // A one-cycle drive window acks in its only cycle.
                    rd_ack_nxt = (DRIVE_CYCLES == 1);
                end
`ifdef LATCH373_CTL_OVERWRITE_EN
                else if (load_req) begin
                    // Overwrite: full stays set while the latch reopens.
                    state_nxt   = ST_OPEN;
                    cnt_nxt     = OPEN_LD;
                    hold_n_nxt  = 1'b1;
                    overrun_set = 1'b1;
                end
`endif
            end

            ST_DRIVE: begin
                if (cnt == CNT_ONE) begin
                    state_nxt  = ST_IDLE;
                    oenb_n_nxt = 1'b1;
                    full_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                    // rd_ack is registered, so raise it one edge early to
                    // land in the final drive cycle.
                    rd_ack_nxt = (DRIVE_CYCLES >= 2) && (cnt == CNT_TWO);
                end
            end

            default: begin
                state_nxt  = ST_IDLE;
                hold_n_nxt = 1'b0;
                oenb_n_nxt = 1'b1;
                full_nxt   = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_FULL);
    end

    // State, counter and output registers with asynchronous reset to a safe
    // latch configuration (holding, outputs disabled).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            hold_n   <= 1'b0;
            oenb_n   <= 1'b1;
            full     <= 1'b0;
            load_ack <= 1'b0;
            rd_ack   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            hold_n   <= hold_n_nxt;
            oenb_n   <= oenb_n_nxt;
            full     <= full_nxt;
            load_ack <= load_ack_nxt;
            rd_ack   <= rd_ack_nxt;
            busy     <= busy_nxt;
        end
    end

`ifdef LATCH373_CTL_OVERWRITE_EN
    // Sticky overwrite flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;

    // overrun_set can never assert without the overwrite feature.
    logic unused_ok;
    assign unused_ok = overrun_set;
`endif

endmodule

// File: tb/tb_latch373_ctl.sv
// Self-checking bench for latch373_ctl (default parameters). A timeline model
// tracks when each load/read transaction started and derives the expected
// outputs from the phase lengths; directed scenarios add literal expectations.
module tb_latch373_ctl;

    localparam int O = 2;
    localparam int S = 1;
    localparam int D = 2;
`ifdef LATCH373_CTL_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_req = 1'b0;
    logic rd_req = 1'b0;
    logic load_ack, rd_ack, hold_n, oenb_n, full, busy, overrun;

    int checks = 0;
    int errors = 0;

    latch373_ctl #(
        .OPEN_CYCLES  (O),
        .SETTLE_CYCLES(S),
        .DRIVE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load_req(load_req),
        .load_ack(load_ack),
        .rd_req  (rd_req),
        .rd_ack  (rd_ack),
        .hold_n  (hold_n),
        .oenb_n  (oenb_n),
        .full    (full),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Timeline model: edge count plus start edge of the active load/read.
    int m_edge, m_ld, m_rd;
    bit m_full, m_ovr, m_lack;

    always @(posedge clk or posedge reset) begin : model
        int e, nl, nr;
        bit nf, no, na;
        if (reset) begin
            m_edge <= 0; m_ld <= -1; m_rd <= -1;
            m_full <= 1'b0; m_ovr <= 1'b0; m_lack <= 1'b0;
        end else begin
            e = m_edge + 1; nl = m_ld; nr = m_rd;
            nf = m_full; no = m_ovr; na = 1'b0;
            if (m_ld >= 0) begin
                if (e == m_ld + O + S) begin nl = -1; nf = 1'b1; na = 1'b1; end
            end else if (m_rd >= 0) begin
                if (e == m_rd + D) begin nr = -1; nf = 1'b0; end
            end else if (!m_full) begin
                if (load_req) nl = e;
            end else if (rd_req) begin
                nr = e;
            end else if (load_req && OVW) begin
                nl = e; no = 1'b1;
            end
            m_edge <= e; m_ld <= nl; m_rd <= nr;
            m_full <= nf; m_ovr <= no; m_lack <= na;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        chk("hold_n",   hold_n,   (m_ld >= 0) && (m_edge < m_ld + O));
        chk("oenb_n",   oenb_n,   !(m_rd >= 0));
        chk("load_ack", load_ack, m_lack);
        chk("rd_ack",   rd_ack,   (m_rd >= 0) && (m_edge == m_rd + D - 1));
        chk("full",     full,     m_full);
        chk("busy",     busy,     (m_ld >= 0) || (m_rd >= 0));
        chk("overrun",  overrun,  m_ovr);
        chk("no_overlap", hold_n & ~oenb_n, 0);
    endtask

    // sel 0 waits for load_ack, sel 1 for rd_ack; n = ticks taken, -1 on timeout.
    task automatic wait_high(input int sel, input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            n++;
            if ((sel == 0) ? load_ack : rd_ack) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_%s: timeout after %0d cycles", (sel == 0) ? "load_ack" : "rd_ack", limit);
        n = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load_req = 1'b0;
        rd_req = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    logic [8:0] v_hold, v_lack, v_full, v_oenb, v_rack, v_busy;
    int n, hcnt, ocnt, acnt;
    bit acked;

    initial begin
        // Reset values.
        repeat (2) tick();
        reset = 1'b0;
        chk("reset_vals", {hold_n, oenb_n, load_ack, rd_ack, full, busy, overrun}, 7'b0100000);

        // Single load then read, edges numbered from the first load_req edge.
        load_req = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            v_hold[i-1] = hold_n; v_lack[i-1] = load_ack; v_full[i-1] = full;
            v_oenb[i-1] = oenb_n; v_rack[i-1] = rd_ack;   v_busy[i-1] = busy;
            if (i == 4) load_req = 1'b0;
            if (i == 5) rd_req = 1'b1;
            if (i == 7) rd_req = 1'b0;
        end
        chk("seq_hold_n",   v_hold, 9'b000000011);
        chk("seq_load_ack", v_lack, 9'b000001000);
        chk("seq_full",     v_full, 9'b001111000);
        chk("seq_oenb_n",   v_oenb, 9'b110011111);
        chk("seq_rd_ack",   v_rack, 9'b001000000);
        chk("seq_busy",     v_busy, 9'b001100111);

        // Asynchronous reset in the middle of OPEN.
        do_reset();
        load_req = 1'b1;
        tick();
        chk("open_before_reset", hold_n, 1);
        #2 reset = 1'b1;
        load_req = 1'b0;
        #1;
        chk("async_rst_open", {hold_n, oenb_n, full, busy}, 4'b0100);
        tick();
        reset = 1'b0;

        // Asynchronous reset in the middle of DRIVE.
        load_req = 1'b1;
        wait_high(0, 20, n);
        load_req = 1'b0;
        rd_req = 1'b1;
        tick();
        chk("drive_before_reset", {oenb_n, full}, 2'b01);
        #2 reset = 1'b1;
        rd_req = 1'b0;
        #1;
        chk("async_rst_drive", {hold_n, oenb_n, full, rd_ack}, 4'b0100);
        tick();
        reset = 1'b0;

        // Read while empty stalls; a later load lets it finish.
        do_reset();
        rd_req = 1'b1;
        ocnt = 0; acnt = 0;
        repeat (10) begin
            tick();
            if (!oenb_n) ocnt++;
            if (rd_ack) acnt++;
        end
        chk("empty_oenb_low_cycles", ocnt, 0);
        chk("empty_rd_ack_cycles", acnt, 0);
        load_req = 1'b1;
        wait_high(0, 20, n);
        chk("empty_load_latency", n, 4);
        load_req = 1'b0;
        wait_high(1, 10, n);
        chk("ack_to_rd_ack", n, 2);
        rd_req = 1'b0;
        tick();
        chk("read_done_3rd_edge", {full, oenb_n}, 2'b01);

        // Simultaneous requests in IDLE: load first, then read.
        do_reset();
        load_req = 1'b1;
        rd_req = 1'b1;
        wait_high(0, 20, n);
        chk("simul_load_latency", n, 4);
        chk("simul_no_early_read", oenb_n, 1);
        load_req = 1'b0;
        wait_high(1, 10, n);
        chk("simul_read_after_load", n, 2);
        rd_req = 1'b0;
        repeat (2) tick();

        // Load while FULL.
        do_reset();
        load_req = 1'b1;
        wait_high(0, 20, n);
        load_req = 1'b0;
        tick();
        load_req = 1'b1;
        hcnt = 0; acked = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (hold_n) hcnt++;
            if (load_ack) begin
                load_req = 1'b0;
                acked = 1'b1;
                break;
            end
        end
        chk("full_load_hold_cycles", hcnt, OVW ? 2 : 0);
        chk("full_load_acked", acked, OVW);
        chk("full_load_overrun", overrun, OVW);
        chk("full_load_full", full, 1);
        // Read still has priority; a stalled load proceeds once it drains.
        rd_req = 1'b1;
        wait_high(1, 10, n);
        rd_req = 1'b0;
        if (load_req) begin
            wait_high(0, 20, n);
            load_req = 1'b0;
        end
        repeat (3) tick();
        chk("overrun_sticky", overrun, OVW);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
